// File: rtl/run_seq_pkg.sv
// Shared types and defaults for the run sequencer: FSM state encoding and
// default timing constants.
package run_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARMED = 3'd1,
        INIT  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } run_state_t;

    localparam int unsigned RUN_SEQ_CORE_RST_CYCLES = 2;
    localparam int unsigned RUN_SEQ_WDOG_LIMIT      = 32'h0000_FFFF;

    // Width of a down-counter that must hold values 0..n-1 (never narrower than 1 bit).
    function automatic int unsigned init_cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and count enable; holds at
// all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_at_max;

    assign w_at_max = (r_count == {CNT_W{1'b1}});

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !w_at_max) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/run_sequencer.sv
// Run controller: Start/Ack handshake to core reset/run sequencing with a cycle
// counter. Optional watchdog enabled by defining RUN_SEQ_WATCHDOG_EN.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int unsigned CORE_RST_CYCLES = RUN_SEQ_CORE_RST_CYCLES,
    parameter int unsigned CYCLE_W         = 16,
    parameter int unsigned WDOG_LIMIT      = RUN_SEQ_WDOG_LIMIT
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               CoreDone,
    output logic               CoreReset,
    output logic               CoreRun,
    output logic               Ack,
    output logic               Busy,
    output logic [CYCLE_W-1:0] CycleCount,
    output logic               Timeout
);

    localparam int unsigned INIT_W = init_cnt_width(CORE_RST_CYCLES);
    // Compare the counter against the limit at a common width so a narrow
    // counter never matches a truncated limit.
    localparam int unsigned CMP_W  = (CYCLE_W > 32) ? CYCLE_W : 32;

    run_state_t          r_state;
    run_state_t          w_next_state;
    logic [INIT_W-1:0]   r_init_cnt;
    logic                r_start_prev;
    logic                r_core_reset;
    logic                r_core_run;
    logic                r_ack;
    logic                r_busy;
    logic                r_timeout;
    logic                w_start_rise;
    logic                w_init_entry;
    logic                w_wdog_fire;
    logic                w_cnt_clr;
    logic                w_cnt_en;
    logic [CYCLE_W-1:0]  w_cycle_count;

    assign w_start_rise = Start && !r_start_prev;
    assign w_init_entry = (r_state == ARMED) && !Start;

`ifdef RUN_SEQ_WATCHDOG_EN
    assign w_wdog_fire = (r_state == RUN) && !CoreDone &&
                         (CMP_W'(w_cycle_count) == CMP_W'(WDOG_LIMIT));
`else
    logic w_wdog_unused;
    assign w_wdog_unused = ^(CMP_W'(WDOG_LIMIT));
    assign w_wdog_fire   = 1'b0;
`endif

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (Start)                    w_next_state = ARMED;
            ARMED:   if (!Start)                   w_next_state = INIT;
            INIT:    if (r_init_cnt == '0)         w_next_state = RUN;
            RUN:     if (CoreDone || w_wdog_fire)  w_next_state = DONE;
            // Only a fresh rising edge re-arms; a level held since RUN is ignored.
            DONE:    if (w_start_rise)             w_next_state = ARMED;
            default:                               w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state      <= IDLE;
            r_start_prev <= 1'b0;
            r_core_reset <= 1'b1;
            r_core_run   <= 1'b0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_start_prev <= Start;
            // Outputs are decoded from the next state so they are registered yet
            // line up with the state they describe.
            r_core_reset <= (w_next_state == IDLE) || (w_next_state == ARMED) ||
                            (w_next_state == INIT);
            r_core_run   <= (w_next_state == RUN);
            r_ack        <= (w_next_state == DONE);
            r_busy       <= (w_next_state == ARMED) || (w_next_state == INIT) ||
                            (w_next_state == RUN);
            if (w_init_entry) begin
                r_timeout <= 1'b0;
            end else if (w_wdog_fire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (w_init_entry) begin
            r_init_cnt <= INIT_W'(CORE_RST_CYCLES - 1);
        end else if ((r_state == INIT) && (r_init_cnt != '0)) begin
            r_init_cnt <= r_init_cnt - INIT_W'(1);
        end
    end

    // The completing RUN cycle is counted; a watchdog abort leaves the count at the limit.
    assign w_cnt_clr = !Reset || w_init_entry;
    assign w_cnt_en  = (r_state == RUN) && !w_wdog_fire;

    sat_counter #(
        .CNT_W (CYCLE_W)
    ) u_cycle_cnt (
        .i_clk   (Clk),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_cycle_count)
    );

    assign CoreReset  = r_core_reset;
    assign CoreRun    = r_core_run;
    assign Ack        = r_ack;
    assign Busy       = r_busy;
    assign CycleCount = w_cycle_count;
    assign Timeout    = r_timeout;

endmodule

// File: tb/tb_run_sequencer.sv
// Self-checking bench for run_sequencer: reset values, table-driven and
// randomized runs against a reference model, plus multi-cycle corner sequences.
module tb_run_sequencer;

    localparam int RST  = 2;
    localparam int WDOG = 20;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic        CoreDone;
    logic        CoreReset;
    logic        CoreRun;
    logic        Ack;
    logic        Busy;
    logic [15:0] CycleCount;
    logic        Timeout;

    logic        Start_b;
    logic        CoreDone_b;
    logic        CoreReset_b;
    logic        CoreRun_b;
    logic        Ack_b;
    logic        Busy_b;
    logic [3:0]  CycleCount_b;
    logic        Timeout_b;

    int checks = 0;
    int errors = 0;
    int last_count = 0;

    always #5 Clk = ~Clk;

    run_sequencer #(
        .CORE_RST_CYCLES (RST),
        .CYCLE_W         (16),
        .WDOG_LIMIT      (WDOG)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .CoreDone   (CoreDone),
        .CoreReset  (CoreReset),
        .CoreRun    (CoreRun),
        .Ack        (Ack),
        .Busy       (Busy),
        .CycleCount (CycleCount),
        .Timeout    (Timeout)
    );

    run_sequencer #(
        .CORE_RST_CYCLES (RST),
        .CYCLE_W         (4)
    ) dut_narrow (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start_b),
        .CoreDone   (CoreDone_b),
        .CoreReset  (CoreReset_b),
        .CoreRun    (CoreRun_b),
        .Ack        (Ack_b),
        .Busy       (Busy_b),
        .CycleCount (CycleCount_b),
        .Timeout    (Timeout_b)
    );

    typedef struct {
        int hold;
        int k;
        int exp_cnt;
        bit exp_to;
        int exp_run;
    } vec_t;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: a run lasts k RUN cycles and counts k, unless the watchdog
    // cuts it short one cycle after the count reaches the limit.
    function automatic void model(input int k, output int cnt, output bit to, output int run);
        cnt = k;
        to  = 1'b0;
        run = k;
`ifdef RUN_SEQ_WATCHDOG_EN
        if (k > WDOG + 1) begin
            cnt = WDOG;
            to  = 1'b1;
            run = WDOG + 1;
        end
`endif
    endfunction

    // From INIT entry: measure reset length, drive k RUN cycles, check DONE.
    task automatic finish_run(input int k, input int exp_cnt, input bit exp_to,
                              input int exp_run, input bit toggle, input bit start_at_end);
        int init_cycles;
        int run;
        check("init_clears_count", CycleCount, 0);
        check("init_clears_timeout", Timeout, 0);
        init_cycles = 0;
        while (CoreReset && init_cycles < 50) begin
            init_cycles++;
            tick();
        end
        check("init_len", init_cycles, RST);
        check("run_entry_corerun", CoreRun, 1);
        run = 0;
        while (CoreRun && run < k + 30) begin
            run++;
            CoreDone = (run == k);
            if (run == k) Start = start_at_end;
            else          Start = toggle ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        CoreDone = 1'b0;
        check("run_len", run, exp_run);
        check("done_ack", Ack, 1);
        check("done_corerun", CoreRun, 0);
        check("done_corereset", CoreReset, 0);
        check("done_busy", Busy, 0);
        check("done_count", CycleCount, exp_cnt);
        check("done_timeout", Timeout, exp_to);
        if (!start_at_end) begin
            Start = 1'b0;
            tick();
            check("ack_hold", Ack, 1);
        end
        last_count = exp_cnt;
    endtask

    task automatic do_run(input int hold, input int k, input int exp_cnt, input bit exp_to,
                          input int exp_run, input bit toggle);
        Start = 1'b1;
        tick();
        check("armed_busy", Busy, 1);
        check("armed_ack", Ack, 0);
        check("armed_corereset", CoreReset, 1);
        check("armed_keeps_count", CycleCount, last_count);
        for (int i = 1; i < hold; i++) tick();
        Start = 1'b0;
        tick();
        finish_run(k, exp_cnt, exp_to, exp_run, toggle, 1'b0);
    endtask

    vec_t tbl[5];

    initial begin
        int cnt;
        bit to;
        int run;
        int k;
        int n;

        tbl[0] = '{hold: 3, k: 10, exp_cnt: 10, exp_to: 1'b0, exp_run: 10};
        tbl[1] = '{hold: 1, k: 1,  exp_cnt: 1,  exp_to: 1'b0, exp_run: 1};
        tbl[2] = '{hold: 2, k: 5,  exp_cnt: 5,  exp_to: 1'b0, exp_run: 5};
        tbl[3] = '{hold: 1, k: 21, exp_cnt: 21, exp_to: 1'b0, exp_run: 21};
`ifdef RUN_SEQ_WATCHDOG_EN
        tbl[4] = '{hold: 1, k: 35, exp_cnt: 20, exp_to: 1'b1, exp_run: 21};
`else
        tbl[4] = '{hold: 1, k: 35, exp_cnt: 35, exp_to: 1'b0, exp_run: 35};
`endif

        Reset = 1'b0;
        Start = 1'b0;
        CoreDone = 1'b0;
        Start_b = 1'b0;
        CoreDone_b = 1'b0;
        tick();
        tick();
        check("rst_corereset", CoreReset, 1);
        check("rst_corerun", CoreRun, 0);
        check("rst_ack", Ack, 0);
        check("rst_busy", Busy, 0);
        check("rst_count", CycleCount, 0);
        check("rst_timeout", Timeout, 0);
        Reset = 1'b1;
        tick();
        check("idle_corereset", CoreReset, 1);
        check("idle_busy", Busy, 0);
        check("idle_ack", Ack, 0);

        foreach (tbl[i]) do_run(tbl[i].hold, tbl[i].k, tbl[i].exp_cnt, tbl[i].exp_to,
                                tbl[i].exp_run, 1'b0);

        for (int i = 0; i < 20; i++) begin
            k = int'($urandom_range(1, 40));
            model(k, cnt, to, run);
            do_run(int'($urandom_range(1, 4)), k, cnt, to, run, 1'b1);
        end

        // Start rises together with CoreDone and stays high: no re-arm until a fresh edge.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        finish_run(8, 8, 1'b0, 8, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("held_start_ack", Ack, 1);
            check("held_start_busy", Busy, 0);
        end
        Start = 1'b0;
        tick();
        check("start_fall_ack", Ack, 1);
        Start = 1'b1;
        tick();
        check("rearm_ack", Ack, 0);
        check("rearm_busy", Busy, 1);
        check("rearm_keeps_count", CycleCount, 8);
        Start = 1'b0;
        tick();
        finish_run(3, 3, 1'b0, 3, 1'b0, 1'b0);

        // Reset mid-RUN aborts the run.
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        n = 0;
        while (!CoreRun && n < 20) begin
            n++;
            tick();
        end
        for (int i = 0; i < 5; i++) tick();
        check("midrun_count", CycleCount, 5);
        Reset = 1'b0;
        tick();
        check("abort_corerun", CoreRun, 0);
        check("abort_corereset", CoreReset, 1);
        check("abort_ack", Ack, 0);
        check("abort_busy", Busy, 0);
        check("abort_count", CycleCount, 0);
        Reset = 1'b1;
        tick();
        check("abort_idle_busy", Busy, 0);
        last_count = 0;
        do_run(1, 4, 4, 1'b0, 4, 1'b0);

        // Narrow counter saturates at 15 without wrapping.
        Start_b = 1'b1;
        tick();
        Start_b = 1'b0;
        tick();
        n = 0;
        while (!CoreRun_b && n < 20) begin
            n++;
            tick();
        end
        check("narrow_run_entry", n, RST);
        for (int r = 1; r <= 20; r++) begin
            CoreDone_b = (r == 20);
            tick();
            if (r == 17) check("narrow_sat_mid", CycleCount_b, 15);
        end
        CoreDone_b = 1'b0;
        check("narrow_ack", Ack_b, 1);
        check("narrow_count", CycleCount_b, 15);
        check("narrow_timeout", Timeout_b, 0);
        check("narrow_corerun", CoreRun_b, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
